cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Board-side run controller that sits directly upstream of the pipelined CPU/memory top. It turns the raw `start` button and `enable` switch, clocked by `boardCLK`, into three things for the CPU: a divided CPU clock-enable, a clean one-cycle start pulse, and a run/halt state. It also keeps a saturating count of executed CPU cycles for on-board display and bench checking.

## Interface
- `DIV`, 4: CPU clock-enable period in boardCLK cycles; legal range ≥2.
- `DEBOUNCE`, 16: number of consecutive stable-high synchronized samples `start` needs before it is accepted; legal range ≥1.
- `CNT_W`, 32: width of `cycle_cnt`.

- `boardCLK`  in  1  single clock for the whole block.
- `clk_reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  raw, asynchronous, bouncing push-button.
- `enable`  in  1  level; low freezes the divider and the counter.
- `halt`  in  1  from the CPU; high means the CPU has executed a halt.
- `step`  in  1  raw single-step button; present only with `SINGLE_STEP_EN`.
- `cpu_ce`  out  1  one-boardCLK-wide CPU clock-enable pulse.
- `start_pulse`  out  1  one-cycle pulse on an accepted start press.
- `running`  out  1  high while in RUN.
- `cycle_cnt`  out  CNT_W  number of `cpu_ce` pulses since the last start.

## Operation
- Input conditioning: `start` (and `step`) pass through 2-flop synchronizers, then a debounce counter.
  - The counter increments while the synchronized level is high and clears when it is low.
  - At DEBOUNCE the level is accepted; the acceptance is edge-detected.
  - `start_pulse` fires once per press. It does not fire again until the level has gone low.
- States: IDLE, RUN and HALTED, plus STEP with the macro.
  - IDLE: on `start_pulse` & `enable`, go to RUN and clear `cycle_cnt` and the divider. `start_pulse` with `enable` low is ignored.
  - RUN: the divider counts 0..DIV-1 while `enable`=1 and holds while `enable`=0. `cpu_ce`=1 in the cycle where divider==DIV-1 and `enable`=1.
  - RUN: `halt` sampled high goes to HALTED in the next cycle. No `cpu_ce` is issued in the transition cycle or afterwards.
  - HALTED: `start_pulse` & `enable` go to RUN, clearing `cycle_cnt` and the divider.
  - RUN with `start_pulse` is ignored; it does not restart.
- `cycle_cnt` increments on each `cpu_ce` and saturates at all-ones.
- `halt` and the divider wrap in the same cycle: the `cpu_ce` for that cycle is suppressed, and the state goes to HALTED.

## Timing
- Reset values: `cpu_ce`=0, `start_pulse`=0, `running`=0, `cycle_cnt`=0, state=IDLE, divider=0, synchronizers and debounce=0.
- `clk_reset` asserted mid-operation takes effect at the next edge. It overrides everything, including a concurrent `start_pulse`.
- A raw `start` rising before edge t, then held stable, gives `start_pulse` high in cycle t+2+DEBOUNCE.
- `running` rises the cycle after `start_pulse`.
- The first `cpu_ce` comes DIV cycles after `running` rises, with `enable` held high. After that, `cpu_ce` repeats every DIV cycles.
- `halt` high in cycle h gives `running` low at h+1.
- All outputs are registered.

## Configuration
- `SINGLE_STEP_EN` defined:
  - The `step` port exists and is conditioned like `start`.
  - An accepted step in HALTED or IDLE, with `enable`=1, enters STEP.
  - STEP emits exactly one `cpu_ce` in the following cycle, increments `cycle_cnt`, and returns to the prior state (IDLE or HALTED).
  - `running` stays 0 throughout.
- `SINGLE_STEP_EN` undefined: there is no `step` port and no STEP state. The behaviour is otherwise identical.

## Test plan
- Reset: assert `clk_reset` for 5 cycles, then deassert → all outputs 0, and no `cpu_ce` for 100 cycles.
- Debounce: DEBOUNCE=16; toggle `start` every 3 cycles for 30 cycles, then hold it high → exactly one `start_pulse`, 18 cycles after the final rise. A glitch shorter than 16 cycles gives no pulse.
- Run cadence: DIV=4, `enable`=1, start → `cpu_ce` at running+4, +8, +12, …; after 10 pulses `cycle_cnt`=10. Drop `enable` for 7 cycles → the divider holds, with no pulses and no count change.
- Halt: assert `halt` on the cycle of the 5th `cpu_ce` → that pulse is suppressed, `cycle_cnt`=4, and `running`=0 next cycle. Press start again → `cycle_cnt` clears to 0 and RUN resumes.
- Saturation: CNT_W=4, run 20 pulses → `cycle_cnt` holds at 15.
- With `SINGLE_STEP_EN`: in HALTED, press step → exactly one `cpu_ce`, `cycle_cnt`+1, state returns to HALTED, and `running` stays 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Board-side run controller: conditions start/step buttons and drives cpu_ce, start_pulse and running.
// It also keeps a saturating count of cpu_ce pulses in cycle_cnt.
// Latency: start_pulse appears 2+DEBOUNCE cycles after a clean press; running rises one cycle later.
// The first cpu_ce follows DIV enabled cycles after that. A halt drops running one cycle later.
// Backpressure: none. enable low freezes the divider and the count. halt ends RUN.
//
// Ports:
//   boardCLK, clk_reset   single clock; synchronous active-high reset
//   start, step           raw asynchronous buttons (step only with SINGLE_STEP_EN)
//   enable, halt          run gate level; CPU halt indication
//   cpu_ce, start_pulse   one-cycle CPU clock-enable; one-cycle accepted start press
//   running, cycle_cnt    high in RUN; saturating count of cpu_ce since the last start
// Optional feature macro: SINGLE_STEP_EN adds the step port and the STEP state.

// Button conditioner: 2-flop synchronizer, then a debounce counter, then a rising-edge detect.
// Latency: pulse appears 2+DEBOUNCE cycles after raw settles high.
// Backpressure: none. One pulse per press; the level must fall before another press is accepted.
module cpu_run_ctrl_btn #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic            accepted;
    logic            accepted_q;

    assign accepted = (db_cnt == DB_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_cnt     <= '0;
            accepted_q <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // The counter saturates at DEBOUNCE so a long press stays accepted without wrapping.
            if (!sync2)
                db_cnt <= '0;
            else if (!accepted)
                db_cnt <= db_cnt + DB_W'(1);
            accepted_q <= accepted;
            pulse      <= accepted & ~accepted_q;
        end
    end
endmodule

module cpu_run_ctrl #(
    parameter int DIV      = 4,
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 32
) (
    input  logic             boardCLK,
    input  logic             clk_reset,
    input  logic             start,
    input  logic             enable,
    input  logic             halt,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             cpu_ce,
    output logic             start_pulse,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
`ifdef SINGLE_STEP_EN
    localparam logic [1:0] ST_STEP   = 2'd3;
`endif

    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             wrap;
    logic             cnt_sat;

    assign wrap    = enable && (div_cnt == DIV_LAST);
    assign cnt_sat = (cycle_cnt == CNT_MAX);

    cpu_run_ctrl_btn #(.DEBOUNCE(DEBOUNCE)) u_start_btn (
        .clk   (boardCLK),
        .rst   (clk_reset),
        .raw   (start),
        .pulse (start_pulse)
    );

`ifdef SINGLE_STEP_EN
    logic       step_pulse;
    logic [1:0] step_ret;   // state to resume after the single step (IDLE or HALTED)

    cpu_run_ctrl_btn #(.DEBOUNCE(DEBOUNCE)) u_step_btn (
        .clk   (boardCLK),
        .rst   (clk_reset),
        .raw   (step),
        .pulse (step_pulse)
    );
`endif

    always_ff @(posedge boardCLK) begin
        if (clk_reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            cpu_ce    <= 1'b0;
            running   <= 1'b0;
            cycle_cnt <= '0;
`ifdef SINGLE_STEP_EN
            step_ret  <= ST_IDLE;
`endif
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (enable)
                        div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
                    // A halt seen in the wrap cycle wins, so that cpu_ce is never issued.
                    if (halt) begin
                        state   <= ST_HALTED;
                        running <= 1'b0;
                    end else if (wrap) begin
                        cpu_ce <= 1'b1;
                        if (!cnt_sat)
                            cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
`ifdef SINGLE_STEP_EN
                ST_STEP: begin
                    cpu_ce <= 1'b1;
                    if (!cnt_sat)
                        cycle_cnt <= cycle_cnt + 1'b1;
                    state <= step_ret;
                end
`endif
                default: begin
                    // IDLE and HALTED: a start press takes priority over a step press.
                    if (start_pulse && enable) begin
                        state     <= ST_RUN;
                        running   <= 1'b1;
                        div_cnt   <= '0;
                        cycle_cnt <= '0;
                    end
`ifdef SINGLE_STEP_EN
                    else if (step_pulse && enable) begin
                        state    <= ST_STEP;
                        step_ret <= state;
                    end
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed phases followed by random button, enable, halt and reset traffic.
// Every cycle is compared against a counting reference model.
// Latency: none (stimulus only). Backpressure: not applicable.
module tb_cpu_run_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 16;
    localparam int CW  = 32;
    localparam int SW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clk_reset, start, enable, halt;
`ifdef SINGLE_STEP_EN
    logic step;
`endif
    logic          cpu_ce, start_pulse, running;
    logic [CW-1:0] cycle_cnt;
    logic          ce_s, sp_s, run_s;
    logic [SW-1:0] cnt_s;

    cpu_run_ctrl #(.DIV(DIV), .DEBOUNCE(DEB), .CNT_W(CW)) dut (
        .boardCLK (clk), .clk_reset (clk_reset), .start (start), .enable (enable), .halt (halt),
`ifdef SINGLE_STEP_EN
        .step (step),
`endif
        .cpu_ce (cpu_ce), .start_pulse (start_pulse), .running (running), .cycle_cnt (cycle_cnt)
    );

    cpu_run_ctrl #(.DIV(DIV), .DEBOUNCE(DEB), .CNT_W(SW)) dut_sat (
        .boardCLK (clk), .clk_reset (clk_reset), .start (start), .enable (enable), .halt (halt),
`ifdef SINGLE_STEP_EN
        .step (step),
`endif
        .cpu_ce (ce_s), .start_pulse (sp_s), .running (run_s), .cycle_cnt (cnt_s)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. A press is accepted once DEBOUNCE consecutive raw samples are high; the pulse
    // shows three edges after the last of those samples (two sync stages plus the registered pulse).
    // In RUN, every DIV-th enabled cycle produces a cpu_ce in the next cycle, unless halt is high.
    int     cyc = 0;
    int     hr[3];           // consecutive-high run length of raw start at edges n-3, n-2, n-1
    bit     m_pulse, m_run, m_ce;
    int     kdiv;            // enabled RUN cycles since the last start
    longint mcnt;            // cpu_ce pulses since the last start (uncapped)
`ifdef SINGLE_STEP_EN
    int     shr[3];
    bit     m_spulse, m_step;
`endif

    always @(posedge clk) begin : model
        bit p_old, new_p;
        int h;
        cyc++;
        p_old = m_pulse;
        new_p = (hr[0] == DEB);
        h = start ? hr[2] + 1 : 0;
        hr[0] = hr[1]; hr[1] = hr[2]; hr[2] = h;
`ifdef SINGLE_STEP_EN
        begin : step_model
            bit sp_old, new_sp;
            int hs;
            sp_old = m_spulse;
            new_sp = (shr[0] == DEB);
            hs = step ? shr[2] + 1 : 0;
            shr[0] = shr[1]; shr[1] = shr[2]; shr[2] = hs;
            m_ce = 1'b0;
            if (clk_reset) begin
                shr = '{0, 0, 0}; m_spulse = 1'b0; m_step = 1'b0;
            end else begin
                m_spulse = new_sp;
                if (m_step) begin
                    m_ce = 1'b1; mcnt++; m_step = 1'b0;
                    p_old = 1'b0;  // a start press arriving during STEP is dropped
                end else if (!m_run && !(p_old && enable) && sp_old && enable) begin
                    m_step = 1'b1;
                end
            end
        end
`else
        m_ce = 1'b0;
`endif
        if (clk_reset) begin
            hr = '{0, 0, 0}; m_pulse = 1'b0; m_run = 1'b0; mcnt = 0; kdiv = 0;
        end else begin
            m_pulse = new_p;
            if (m_run) begin
                if (enable) kdiv++;
                if (halt) m_run = 1'b0;
                else if (enable && (kdiv % DIV == 0)) begin m_ce = 1'b1; mcnt++; end
            end else if (p_old && enable) begin
                m_run = 1'b1; kdiv = 0; mcnt = 0;
            end
        end
    end

    bit chk_on = 1'b0;
    int ce_seen = 0, sp_seen = 0, sp_cyc = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cpu_ce", cpu_ce, m_ce);
            chk("start_pulse", start_pulse, m_pulse);
            chk("running", running, m_run);
            chk("cycle_cnt", cycle_cnt, mcnt);
            chk("sat_cpu_ce", ce_s, m_ce);
            chk("sat_start_pulse", sp_s, m_pulse);
            chk("sat_running", run_s, m_run);
            chk("sat_cycle_cnt", cnt_s, (mcnt > 15) ? 15 : mcnt);
            if (cpu_ce) ce_seen++;
            if (start_pulse) begin sp_seen++; sp_cyc = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input int hold);
        start = 1'b1; tick(hold); start = 1'b0;
    endtask

    initial begin
        int c0, s0, rise, b;
        clk_reset = 1'b1; start = 1'b0; enable = 1'b1; halt = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(1);
        chk_on = 1'b1;
        tick(4);
        clk_reset = 1'b0;
        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_start_pulse", start_pulse, 0);
        chk("rst_running", running, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);

        // Idle after reset: no clock enables whatever enable does.
        c0 = ce_seen;
        for (int i = 0; i < 100; i++) begin enable = ($urandom_range(0, 1) == 1); tick(1); end
        chk("idle_no_ce", ce_seen - c0, 0);

        // Bouncing press (enable low, so it must not start the CPU), then a clean hold.
        enable = 1'b0;
        s0 = sp_seen;
        for (int i = 0; i < 10; i++) begin start = ~start; tick(3); end
        start = 1'b1; rise = cyc + 1;
        tick(25); start = 1'b0; tick(5);
        chk("deb_count", sp_seen - s0, 1);
        chk("deb_latency", sp_cyc - rise, DEB + 2);
        chk("deb_ignored_run", running, 0);

        // A glitch one sample short of the debounce length.
        s0 = sp_seen;
        press(DEB - 1); tick(10);
        chk("glitch_no_pulse", sp_seen - s0, 0);

        // Run cadence.
        enable = 1'b1;
        c0 = ce_seen;
        press(20);
        chk("run_started", running, 1);
        chk("run_cnt0", cycle_cnt, 0);
        b = 0;
        while (ce_seen - c0 < 10 && b < 200) begin tick(1); b++; end
        chk("run_ce10_timeout", b < 200, 1);
        chk("run_cnt10", cycle_cnt, 10);

        // enable low for 7 cycles freezes everything.
        enable = 1'b0; c0 = ce_seen;
        tick(7);
        chk("en_hold_ce", ce_seen - c0, 0);
        chk("en_hold_cnt", cycle_cnt, 10);
        enable = 1'b1;

        // Plain halt, then a restart, then a halt on the cycle that would issue the 5th cpu_ce.
        tick($urandom_range(1, 10));
        halt = 1'b1; tick(1); halt = 1'b0;
        chk("halt_running", running, 0);
        tick(3);
        press(20);
        chk("restart_running", running, 1);
        chk("restart_cnt", cycle_cnt, 0);
        b = 0;
        while (!(m_run && mcnt == 4 && ((kdiv + 1) % DIV == 0)) && b < 300) begin tick(1); b++; end
        chk("halt5_timeout", b < 300, 1);
        halt = 1'b1; tick(1); halt = 1'b0;
        chk("halt5_ce", cpu_ce, 0);
        chk("halt5_cnt", cycle_cnt, 4);
        chk("halt5_running", running, 0);
        tick(DIV * 3);
        chk("halted_cnt_kept", cycle_cnt, 4);

`ifdef SINGLE_STEP_EN
        // Single step from HALTED.
        c0 = ce_seen;
        step = 1'b1; tick(20); step = 1'b0; tick(5);
        chk("step_ce", ce_seen - c0, 1);
        chk("step_cnt", cycle_cnt, 5);
        chk("step_running", running, 0);
`endif

        // Restart and run past the 4-bit saturation point.
        press(20);
        c0 = ce_seen; b = 0;
        while (ce_seen - c0 < 20 && b < 400) begin tick(1); b++; end
        tick(1);
        chk("sat_timeout", b < 400, 1);
        chk("sat_cnt15", cnt_s, 15);
        chk("wide_cnt20", cycle_cnt, 20);

        // Random traffic against the model.
        begin
            int start_left = 0;
            for (int i = 0; i < 3000; i++) begin
                if (start_left > 0) begin
                    start_left--;
                    if (start_left == 0) start = 1'b0;
                end else if ($urandom_range(0, 59) == 0) begin
                    start = 1'b1; start_left = $urandom_range(4, 40);
                end
`ifdef SINGLE_STEP_EN
                step = ($urandom_range(0, 199) == 0) ? 1'b1 : (step && $urandom_range(0, 24) != 0);
`endif
                enable    = ($urandom_range(0, 7) != 0);
                halt      = ($urandom_range(0, 39) == 0);
                clk_reset = ($urandom_range(0, 599) == 0);
                tick(1);
            end
        end
        clk_reset = 1'b0; start = 1'b0; halt = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
